// File: rtl/param_pc_uop_sequencer.sv
// -----------------------------------------------------------------------------
// param_pc_uop_sequencer
//
// Micro-op sequencer for the nibble-serial PC computation datapath. Decode
// hands over one control-flow class per instruction; the sequencer then drives
// every select and enable of the datapath, cycle by cycle:
//   - TGT    : C_N_OFF nibble cycles serialising the target address into the
//              address deserialising register.
//   - CMP    : C_N_OFF nibble cycles of serial branch-condition evaluation
//              (branches only).
//   - COMMIT : a single cycle on which pc is updated.
//
// Optional feature macro: PC_SEQ_MISALIGN_CHECK_EN
//   When defined, bits [1:0] of the first target nibble are captured. A
//   redirect to a misaligned target is suppressed at COMMIT and misalign_exc
//   pulses instead. When undefined, misalign_exc is tied to 0.
//
// Handshake: decode holds req_val/req_type; a request is accepted on a rising
// clk edge where req_val && req_rdy. req_rdy is high only in IDLE, and is
// dropped while stall or kill is asserted so no request is taken on a frozen
// or squashed cycle. resp_val pulses for one cycle when a sequence commits.
//
// Ports:
//   clk, reset_n              clock, asynchronous active-low reset
//   req_val, req_rdy          request handshake from decode
//   req_type[1:0]             00 seq, 01 branch, 10 jal, 11 jalr
//   stall                     freeze state/counter, gate advancing controls
//   kill                      squash the in-flight sequence (beats stall)
//   br_cond_Xhl               serial compare result, valid on last CMP nibble
//   alu_nibble_lo_Xhl[1:0]    low bits of ALU nibble (misalignment check only)
//   last_uop_Xhl              commit micro-op, pc updates this cycle
//   pc_mux_sel_Xhl            select redirect target on commit
//   b_use_imm_reg_Xhl         address register holds a valid target
//   pc_plus4_mux_sel_Xhl      PC+4 nibble stream select (kept 0: PC stream)
//   a_mux_sel_Xhl             ALU A operand: 1 = PC nibble, 0 = rs1 nibble
//   shift_dir_sel_Xhl         address register fill direction (0 = LSB first)
//   addr_reg_en_Xhl           advance/capture address register
//   resp_val                  one-cycle completion pulse
//   misalign_exc              one-cycle misaligned-redirect pulse
//   state_dbg[1:0]            current FSM state (0 IDLE,1 TGT,2 CMP,3 COMMIT)
// -----------------------------------------------------------------------------
module param_pc_uop_sequencer #(
    parameter int P_NBITS   = 4,
    parameter int C_N_OFF   = 8,
    parameter int C_OFFBITS = 3
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       req_val,
    output logic       req_rdy,
    input  logic [1:0] req_type,
    input  logic       stall,
    input  logic       kill,
    input  logic       br_cond_Xhl,
    input  logic [1:0] alu_nibble_lo_Xhl,
    output logic       last_uop_Xhl,
    output logic       pc_mux_sel_Xhl,
    output logic       b_use_imm_reg_Xhl,
    output logic       pc_plus4_mux_sel_Xhl,
    output logic       a_mux_sel_Xhl,
    output logic       shift_dir_sel_Xhl,
    output logic       addr_reg_en_Xhl,
    output logic       resp_val,
    output logic       misalign_exc,
    output logic [1:0] state_dbg
);

    // Word width is fixed by the slice width and nibble count; it is not
    // needed by the control logic itself.
    localparam int unused_word_bits = P_NBITS * C_N_OFF;

    localparam logic [C_OFFBITS-1:0] CNT_LAST = C_OFFBITS'(C_N_OFF - 1);
    localparam logic [C_OFFBITS-1:0] CNT_ONE  = C_OFFBITS'(1);

    localparam logic [1:0] T_SEQ  = 2'b00;
    localparam logic [1:0] T_BR   = 2'b01;
    localparam logic [1:0] T_JALR = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_TGT    = 2'd1,
        S_CMP    = 2'd2,
        S_COMMIT = 2'd3
    } state_t;

    state_t                 state_q;
    state_t                 state_d;
    logic [C_OFFBITS-1:0]   cnt_q;
    logic [1:0]             type_q;
    logic                   taken_q;
    logic                   misaligned;

    // Any cycle on which the datapath must not advance.
    logic gate_off;
    logic accept;
    logic advance;
    logic cnt_last;
    logic redirect;
    logic suppress;

    assign gate_off = stall | kill;
    assign accept   = (state_q == S_IDLE) & req_val & ~gate_off;
    assign advance  = ~gate_off;
    assign cnt_last = (cnt_q == CNT_LAST);

    assign state_dbg = state_q;

    // ---------------------------------------------------------------- state
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (kill) begin
            state_d = S_IDLE;
        end else if (!stall) begin
            case (state_q)
                S_IDLE: begin
                    if (req_val) begin
                        state_d = (req_type == T_SEQ) ? S_COMMIT : S_TGT;
                    end
                end
                S_TGT: begin
                    if (cnt_last) begin
                        state_d = (type_q == T_BR) ? S_CMP : S_COMMIT;
                    end
                end
                S_CMP: begin
                    if (cnt_last) begin
                        state_d = S_COMMIT;
                    end
                end
                S_COMMIT: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------ nibble counter
    // The counter wraps from CNT_LAST to 0 naturally, which lines up with the
    // TGT->CMP hand-over so CMP also starts at nibble 0.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else if (kill || accept) begin
            cnt_q <= '0;
        end else if (advance && (state_q == S_TGT || state_q == S_CMP)) begin
            cnt_q <= cnt_q + CNT_ONE;
        end
    end

    // ---------------------------------------------- request class and taken
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            type_q  <= T_SEQ;
            taken_q <= 1'b0;
        end else if (accept) begin
            type_q  <= req_type;
            taken_q <= 1'b0;
        end else if (advance && state_q == S_CMP && cnt_last) begin
            taken_q <= br_cond_Xhl;
        end
    end

`ifdef PC_SEQ_MISALIGN_CHECK_EN
    // Low two bits of the first target nibble decide alignment of the
    // whole target; later nibbles carry higher address bits.
    logic misaligned_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            misaligned_q <= 1'b0;
        end else if (accept) begin
            misaligned_q <= 1'b0;
        end else if (advance && state_q == S_TGT && cnt_q == '0) begin
            misaligned_q <= (alu_nibble_lo_Xhl != 2'b00);
        end
    end

    assign misaligned = misaligned_q;
`else
    logic unused_alu_nibble;

    assign unused_alu_nibble = ^alu_nibble_lo_Xhl;
    assign misaligned        = 1'b0;
`endif

    // Redirect decision for the commit cycle.
    always_comb begin
        case (type_q)
            T_SEQ:   redirect = 1'b0;
            T_BR:    redirect = taken_q;
            default: redirect = 1'b1;
        endcase
    end

    assign suppress = redirect & misaligned;

    // ------------------------------------------------------------- outputs
    // Selects are Moore; the enables that move the datapath (and the
    // completion pulses) are additionally gated by stall/kill.
    always_comb begin
        req_rdy              = 1'b0;
        last_uop_Xhl         = 1'b0;
        pc_mux_sel_Xhl       = 1'b0;
        b_use_imm_reg_Xhl    = 1'b0;
        pc_plus4_mux_sel_Xhl = 1'b0;
        a_mux_sel_Xhl        = 1'b0;
        shift_dir_sel_Xhl    = 1'b0;
        addr_reg_en_Xhl      = 1'b0;
        resp_val             = 1'b0;
        misalign_exc         = 1'b0;
        case (state_q)
            S_IDLE: begin
                req_rdy = ~gate_off;
            end
            S_TGT: begin
                // pc_plus4_mux_sel stays 0 so the PC shift register rotates.
                addr_reg_en_Xhl = advance;
                a_mux_sel_Xhl   = advance & (type_q != T_JALR);
            end
            S_CMP: begin
                a_mux_sel_Xhl   = 1'b0;
                addr_reg_en_Xhl = 1'b0;
            end
            S_COMMIT: begin
                pc_mux_sel_Xhl    = redirect & ~suppress;
                b_use_imm_reg_Xhl = redirect & ~suppress;
                last_uop_Xhl      = advance & ~suppress;
                resp_val          = advance;
                misalign_exc      = advance & suppress;
            end
            default: begin
                req_rdy = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_param_pc_uop_sequencer.sv
// -----------------------------------------------------------------------------
// Testbench for param_pc_uop_sequencer.
// Inputs are driven 1 time unit after the rising edge; outputs are sampled on
// the falling edge. A driver pushes the expected commit record
// {commit cycle, last_uop, pc_mux_sel, b_use_imm_reg, misalign_exc} into
// exp_q when it issues a request; the monitor pops and compares on resp_val.
// -----------------------------------------------------------------------------
module tb_param_pc_uop_sequencer;

    logic       clk;
    logic       reset_n;
    logic       req_val;
    logic       req_rdy;
    logic [1:0] req_type;
    logic       stall;
    logic       kill;
    logic       br_cond_Xhl;
    logic [1:0] alu_nibble_lo_Xhl;
    logic       last_uop_Xhl;
    logic       pc_mux_sel_Xhl;
    logic       b_use_imm_reg_Xhl;
    logic       pc_plus4_mux_sel_Xhl;
    logic       a_mux_sel_Xhl;
    logic       shift_dir_sel_Xhl;
    logic       addr_reg_en_Xhl;
    logic       resp_val;
    logic       misalign_exc;
    logic [1:0] state_dbg;

    param_pc_uop_sequencer #(
        .P_NBITS   (4),
        .C_N_OFF   (8),
        .C_OFFBITS (3)
    ) dut (
        .clk                  (clk),
        .reset_n              (reset_n),
        .req_val              (req_val),
        .req_rdy              (req_rdy),
        .req_type             (req_type),
        .stall                (stall),
        .kill                 (kill),
        .br_cond_Xhl          (br_cond_Xhl),
        .alu_nibble_lo_Xhl    (alu_nibble_lo_Xhl),
        .last_uop_Xhl         (last_uop_Xhl),
        .pc_mux_sel_Xhl       (pc_mux_sel_Xhl),
        .b_use_imm_reg_Xhl    (b_use_imm_reg_Xhl),
        .pc_plus4_mux_sel_Xhl (pc_plus4_mux_sel_Xhl),
        .a_mux_sel_Xhl        (a_mux_sel_Xhl),
        .shift_dir_sel_Xhl    (shift_dir_sel_Xhl),
        .addr_reg_en_Xhl      (addr_reg_en_Xhl),
        .resp_val             (resp_val),
        .misalign_exc         (misalign_exc),
        .state_dbg            (state_dbg)
    );

    // ------------------------------------------------------ clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    // ---------------------------------------------------------- scoreboard
    localparam int W = 20;
    logic [W-1:0] exp_q[$];
    int checks = 0;
    int passes = 0;

    wire [8:0] dp_outs = {last_uop_Xhl, pc_mux_sel_Xhl, b_use_imm_reg_Xhl,
                          pc_plus4_mux_sel_Xhl, a_mux_sel_Xhl, shift_dir_sel_Xhl,
                          addr_reg_en_Xhl, resp_val, misalign_exc};

    task automatic check_val(input string name, input logic [31:0] act,
                             input logic [31:0] want);
        checks++;
        if (act === want) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, want, cyc);
    endtask

    task automatic push_exp(input int c, input bit l, input bit p,
                            input bit b, input bit m);
        exp_q.push_back({16'(c), l, p, b, m});
    endtask

    logic [W-1:0] mon_got;
    logic [W-1:0] mon_want;

    always @(negedge clk) begin
        if (reset_n) begin
            mon_got = {16'(cyc), last_uop_Xhl, pc_mux_sel_Xhl, b_use_imm_reg_Xhl, misalign_exc};
            if (resp_val) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_resp: got 0x%0h expected none", mon_got);
                end else begin
                    mon_want = exp_q.pop_front();
                    check_val("commit", 32'(mon_got), 32'(mon_want));
                end
            end else if (last_uop_Xhl || misalign_exc) begin
                checks++;
                $display("FAIL stray_uop: got 0x%0h expected no uop without resp_val", mon_got);
            end
        end
    end

    // ------------------------------------------------------------- drivers
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called 1 unit after a rising edge; returns 1 unit after the edge that
    // accepted the request, with tacc = the acceptance cycle T.
    task automatic issue(input logic [1:0] t, output int tacc);
        int n;
        n = 0;
        while (!req_rdy && n < 50) begin
            tick();
            n++;
        end
        if (!req_rdy) begin
            checks++;
            $display("FAIL issue_timeout: got req_rdy 0 expected 1 within 50 cycles");
        end
        req_val  = 1'b1;
        req_type = t;
        tacc     = cyc;
        tick();
        req_val  = 1'b0;
    endtask

    task automatic branch_run(input bit take);
        int t;
        issue(2'b01, t);
        push_exp(t + 17, 1'b1, take, take, 1'b0);
        for (int k = 1; k <= 17; k++) begin
            // Only the last CMP nibble (T+16) may influence the outcome.
            br_cond_Xhl = (k == 16) ? take : ~take;
            @(negedge clk);
            check_val("br_addr_en", addr_reg_en_Xhl, 32'(k <= 8));
            if (k == 1) check_val("br_a_mux_tgt", a_mux_sel_Xhl, 1);
            if (k == 9) check_val("br_a_mux_cmp", a_mux_sel_Xhl, 0);
            tick();
        end
        br_cond_Xhl = 1'b0;
    endtask

    // ------------------------------------------------------------ sequence
    initial begin
        int t;
        int t2;
        int pulses;
        reset_n = 1'b0;
        req_val = 1'b0;
        req_type = 2'b00;
        stall = 1'b0;
        kill = 1'b0;
        br_cond_Xhl = 1'b0;
        alu_nibble_lo_Xhl = 2'b00;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_rdy", req_rdy, 1);
        check_val("rst_outs", dp_outs, 0);
        check_val("rst_state", state_dbg, 0);
        reset_n = 1'b1;
        tick();

        // Sequential: commit at T+1, ready again at T+2
        issue(2'b00, t);
        push_exp(t + 1, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        @(negedge clk);
        check_val("seq_rdy_t2", req_rdy, 1);
        tick();

        // Back-to-back sequential: one per two cycles
        issue(2'b00, t);
        push_exp(t + 1, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        issue(2'b00, t2);
        push_exp(t2 + 1, 1'b1, 1'b0, 1'b0, 1'b0);
        check_val("b2b_accept_gap", 32'(t2 - t), 2);
        tick();

        // Taken and not-taken branches
        branch_run(1'b1);
        branch_run(1'b0);

        // jal with 3 stall cycles starting at cnt = 2 (cycle T+3)
        issue(2'b10, t);
        push_exp(t + 12, 1'b1, 1'b1, 1'b1, 1'b0);
        pulses = 0;
        for (int k = 1; k <= 12; k++) begin
            stall = (k >= 3 && k <= 5);
            @(negedge clk);
            if (addr_reg_en_Xhl) pulses++;
            if (k >= 3 && k <= 5) check_val("stall_addr_en", addr_reg_en_Xhl, 0);
            if (k == 1) check_val("jal_a_mux", a_mux_sel_Xhl, 1);
            tick();
        end
        stall = 1'b0;
        check_val("stall_pulses", pulses, 8);

        // jalr killed at T+5: IDLE at T+6, no commit
        issue(2'b11, t);
        repeat (4) tick();
        kill = 1'b1;
        @(negedge clk);
        check_val("kill_addr_en", addr_reg_en_Xhl, 0);
        tick();
        kill = 1'b0;
        @(negedge clk);
        check_val("kill_state", state_dbg, 0);
        check_val("kill_rdy", req_rdy, 1);
        repeat (4) tick();

        // jalr normal; a request while busy is ignored
        issue(2'b11, t);
        push_exp(t + 9, 1'b1, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        check_val("jalr_a_mux", a_mux_sel_Xhl, 0);
        tick();
        req_val = 1'b1;
        req_type = 2'b00;
        @(negedge clk);
        check_val("busy_rdy", req_rdy, 0);
        tick();
        req_val = 1'b0;
        repeat (7) tick();

        // jal to a misaligned target (nibble 0 low bits = 10)
        issue(2'b10, t);
`ifdef PC_SEQ_MISALIGN_CHECK_EN
        push_exp(t + 9, 1'b0, 1'b0, 1'b0, 1'b1);
`else
        push_exp(t + 9, 1'b1, 1'b1, 1'b1, 1'b0);
`endif
        alu_nibble_lo_Xhl = 2'b10;
        tick();
        alu_nibble_lo_Xhl = 2'b00;
        repeat (8) tick();

        // Aligned jal: only nibble 0 decides alignment, later bits ignored
        issue(2'b10, t);
        push_exp(t + 9, 1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        alu_nibble_lo_Xhl = 2'b11;
        tick();
        alu_nibble_lo_Xhl = 2'b00;
        repeat (7) tick();

        // Asynchronous reset mid-TGT at cnt = 4
        issue(2'b01, t);
        repeat (4) tick();
        check_val("pre_rst_state", state_dbg, 1);
        #1;
        reset_n = 1'b0;
        #1;
        check_val("midrst_state", state_dbg, 0);
        check_val("midrst_rdy", req_rdy, 1);
        check_val("midrst_outs", dp_outs, 0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        tick();
        branch_run(1'b1);

        repeat (3) tick();
        check_val("drain", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
